hazard_stall: RTL and testbench

HAZARD_STALL -- requirements
Module: hazard_stall

---
 rtl/hazard_stall.sv | 86 ++++++++
 tb/tb_hazard_stall.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall.sv
// Pipeline hazard detection: stalls IF/ID on load-use and branch operand hazards,
// squashes IF/ID on taken branches, and counts stall and flush cycles.
module hazard_stall (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  registerRsID,
  input  logic [4:0]  registerRtID,
  input  logic        branchID,
  input  logic        branchTaken,
  input  logic [4:0]  registerRdEX,
  input  logic        regWriteEX,
  input  logic        memReadEX,
  input  logic [4:0]  registerRdMEM,
  input  logic        memReadMEM,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        idExFlush,
  output logic        ifIdFlush,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] stallCount_q, stallCount_d;
  logic [15:0] flushCount_q, flushCount_d;

  logic matchEX, matchMEM;
  logic loadUse, aluBranch, loadBranchEX, loadBranchMEM;
  logic stall, flush;

  // Register 0 is hardwired to zero in the register file, so it never forwards a hazard.
  assign matchEX  = (registerRdEX != 5'd0) &&
                    ((registerRdEX == registerRsID) || (registerRdEX == registerRtID));
  assign matchMEM = (registerRdMEM != 5'd0) &&
                    ((registerRdMEM == registerRsID) || (registerRdMEM == registerRtID));

  assign loadUse       = memReadEX && matchEX;
  assign aluBranch     = branchID && regWriteEX && !memReadEX && matchEX;
  assign loadBranchEX  = branchID && memReadEX && matchEX;
  assign loadBranchMEM = branchID && memReadMEM && matchMEM;

  always_comb begin
    stall   = 1'b0;
    flush   = 1'b0;
    state_d = IDLE;
    if (!reset) begin
      if (state_q == HOLD) begin
        stall = 1'b1;
      end else begin
        stall = loadUse || aluBranch || loadBranchEX || loadBranchMEM;
        if (loadBranchEX) state_d = HOLD;
      end
      // A stalled branch re-evaluates next cycle, so it must not squash the fetch yet.
      flush = branchID && branchTaken && !stall;
    end
  end

  always_comb begin
    stallCount_d = stallCount_q;
    flushCount_d = flushCount_q;
    if (stall && (stallCount_q != 16'hFFFF)) stallCount_d = stallCount_q + 16'd1;
    if (flush && (flushCount_q != 16'hFFFF)) flushCount_d = flushCount_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      stallCount_q <= 16'd0;
      flushCount_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      stallCount_q <= stallCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  assign pcWrite    = !stall;
  assign ifIdWrite  = !stall;
  assign idExFlush  = stall;
  assign ifIdFlush  = flush;
  assign stallCount = stallCount_q;
  assign flushCount = flushCount_q;

endmodule

// File: tb/tb_hazard_stall.sv
// Scoreboard bench for hazard_stall: a behavioural model queues expected outputs
// as each cycle is driven; every scenario task pops and compares them itself.
module tb_hazard_stall;

  logic        clock, reset;
  logic [4:0]  registerRsID, registerRtID, registerRdEX, registerRdMEM;
  logic        branchID, branchTaken, regWriteEX, memReadEX, memReadMEM;
  logic        pcWrite, ifIdWrite, idExFlush, ifIdFlush;
  logic [15:0] stallCount, flushCount;

  hazard_stall dut (
    .clock(clock), .reset(reset),
    .registerRsID(registerRsID), .registerRtID(registerRtID),
    .branchID(branchID), .branchTaken(branchTaken),
    .registerRdEX(registerRdEX), .regWriteEX(regWriteEX), .memReadEX(memReadEX),
    .registerRdMEM(registerRdMEM), .memReadMEM(memReadMEM),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExFlush(idExFlush), .ifIdFlush(ifIdFlush),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  logic        mHold = 1'b0;
  logic [15:0] mStall = 16'd0, mFlush = 16'd0;
  logic [3:0]  obsOut;
  logic [15:0] obsStallCnt, obsFlushCnt;

  // Drive one cycle of inputs (called just after a falling edge) and queue the model's answer.
  task automatic applyStimulus(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                               input logic br, input logic bt, input logic [4:0] rdEx,
                               input logic rwEx, input logic mrEx, input logic [4:0] rdMem,
                               input logic mrMem);
    logic mEx, mMem, s, f, goHold;
    exp_t e;
    reset = rst; registerRsID = rs; registerRtID = rt; branchID = br; branchTaken = bt;
    registerRdEX = rdEx; regWriteEX = rwEx; memReadEX = mrEx;
    registerRdMEM = rdMem; memReadMEM = mrMem;
    mEx  = (rdEx != 0) && (rdEx == rs || rdEx == rt);
    mMem = (rdMem != 0) && (rdMem == rs || rdMem == rt);
    if (rst) begin
      s = 1'b0; f = 1'b0; mStall = 16'd0; mFlush = 16'd0; mHold = 1'b0;
    end else begin
      s = mHold || (mrEx && mEx) || (br && rwEx && !mrEx && mEx) || (br && mrMem && mMem);
      goHold = !mHold && br && mrEx && mEx;
      f = br && bt && !s;
      if (s && mStall != 16'hFFFF) mStall = mStall + 16'd1;
      if (f && mFlush != 16'hFFFF) mFlush = mFlush + 16'd1;
      mHold = goHold;
    end
    e.stall = s; e.flush = f; e.stallCnt = mStall; e.flushCnt = mFlush;
    expQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0);
  endtask

  // Capture combinational outputs mid-cycle and the counters just after the rising edge.
  task automatic cycle();
    #1;
    if (expQ.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL scoreboard-underflow got empty queue need an entry");
      cur.stall = 1'b0; cur.flush = 1'b0; cur.stallCnt = 16'd0; cur.flushCnt = 16'd0;
    end else begin
      cur = expQ.pop_front();
    end
    obsOut = {pcWrite, ifIdWrite, idExFlush, ifIdFlush};
    @(posedge clock); #1;
    obsStallCnt = stallCount;
    obsFlushCnt = flushCount;
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 5'd8, 5'd9, 1, 1, 5'd8, 1, 1, 5'd9, 1);
      cycle();
      checks++;
      if (obsOut !== 4'b1100) begin
        errors++; $display("[TB] FAIL reset-outputs got %b need 1100", obsOut);
      end
    end
    checks++;
    if (obsStallCnt !== 16'd0 || obsFlushCnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset-counters got %h/%h need 0000/0000", obsStallCnt, obsFlushCnt);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(0, 5'd8, 5'd3, 0, 0, 5'd8, 1, 1, 5'd0, 0);
    cycle();
    checks++;
    if (obsOut !== {~cur.stall, ~cur.stall, cur.stall, cur.flush} || obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL load-use-stall got %b need 0010", obsOut);
    end
    idle(); cycle();
    checks++;
    if (obsOut !== 4'b1100) begin
      errors++; $display("[TB] FAIL load-use-release got %b need 1100", obsOut);
    end
    checks++;
    if (obsStallCnt !== cur.stallCnt || obsStallCnt !== 16'd1) begin
      errors++; $display("[TB] FAIL load-use-count got %0d need 1", obsStallCnt);
    end
  endtask

  task automatic test_load_branch();
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0); cycle();
    applyStimulus(0, 5'd1, 5'd9, 1, 0, 5'd9, 1, 1, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL load-branch-cycle1 got %b need 0010", obsOut);
    end
    idle(); cycle();
    checks++;
    if (obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL load-branch-hold got %b need 0010", obsOut);
    end
    applyStimulus(0, 5'd1, 5'd9, 1, 1, 5'd0, 0, 0, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b1101) begin
      errors++; $display("[TB] FAIL load-branch-taken got %b need 1101", obsOut);
    end
    idle(); cycle();
    checks++;
    if (obsStallCnt !== 16'd2 || obsFlushCnt !== 16'd1 || obsStallCnt !== cur.stallCnt) begin
      errors++; $display("[TB] FAIL load-branch-counts got %0d/%0d need 2/1", obsStallCnt, obsFlushCnt);
    end
  endtask

  task automatic test_reg_zero();
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0); cycle();
    applyStimulus(0, 5'd0, 5'd4, 0, 0, 5'd0, 0, 1, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b1100) begin
      errors++; $display("[TB] FAIL reg-zero-loaduse got %b need 1100", obsOut);
    end
    applyStimulus(0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 5'd0, 1); cycle();
    checks++;
    if (obsOut !== 4'b1100 || obsStallCnt !== 16'd0 || obsFlushCnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reg-zero-branch got %b cnt %0d/%0d need 1100 0/0", obsOut, obsStallCnt, obsFlushCnt);
    end
  endtask

  task automatic test_alu_branch_taken();
    applyStimulus(0, 5'd5, 5'd2, 1, 1, 5'd5, 1, 0, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL alu-branch-stall got %b need 0010", obsOut);
    end
    applyStimulus(0, 5'd5, 5'd2, 1, 1, 5'd0, 0, 0, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b1101 || obsFlushCnt !== cur.flushCnt) begin
      errors++; $display("[TB] FAIL alu-branch-flush got %b cnt %0d need 1101 cnt %0d", obsOut, obsFlushCnt, cur.flushCnt);
    end
  endtask

  task automatic test_mem_branch();
    applyStimulus(0, 5'd7, 5'd6, 1, 0, 5'd0, 0, 0, 5'd6, 1); cycle();
    checks++;
    if (obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL mem-branch-stall got %b need 0010", obsOut);
    end
    idle(); cycle();
    checks++;
    if (obsOut !== 4'b1100) begin
      errors++; $display("[TB] FAIL mem-branch-no-hold got %b need 1100", obsOut);
    end
    applyStimulus(0, 5'd7, 5'd6, 0, 0, 5'd7, 1, 0, 5'd6, 1); cycle();
    checks++;
    if (obsOut !== 4'b1100) begin
      errors++; $display("[TB] FAIL non-branch-alu got %b need 1100", obsOut);
    end
  endtask

  task automatic test_reset_in_hold();
    applyStimulus(0, 5'd9, 5'd1, 1, 1, 5'd9, 1, 1, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL hold-reset-cycle1 got %b need 0010", obsOut);
    end
    applyStimulus(1, 5'd9, 5'd1, 1, 1, 5'd9, 1, 1, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b1100 || obsStallCnt !== 16'd0 || obsFlushCnt !== 16'd0) begin
      errors++; $display("[TB] FAIL hold-reset-abort got %b cnt %0d/%0d need 1100 0/0", obsOut, obsStallCnt, obsFlushCnt);
    end
    idle(); cycle();
    checks++;
    if (obsOut !== 4'b1100) begin
      errors++; $display("[TB] FAIL hold-reset-after got %b need 1100", obsOut);
    end
  endtask

  task automatic test_back_to_back();
    // Priority case first: load-branch EX together with MEM and ALU matches still enters HOLD.
    applyStimulus(0, 5'd3, 5'd4, 1, 1, 5'd3, 1, 1, 5'd4, 1); cycle();
    applyStimulus(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 0); cycle();
    checks++;
    if (obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL priority-hold got %b need 0010", obsOut);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 5'(10 + i), 5'd0, 0, 0, 5'(10 + i), 1, 1, 5'd0, 0); cycle();
      checks++;
      if (obsOut !== {~cur.stall, ~cur.stall, cur.stall, cur.flush} || obsStallCnt !== cur.stallCnt) begin
        errors++; $display("[TB] FAIL back-to-back-%0d got %b cnt %0d need %b cnt %0d", i, obsOut,
                           obsStallCnt, {~cur.stall, ~cur.stall, cur.stall, cur.flush}, cur.stallCnt);
      end
    end
  endtask

  task automatic test_saturation();
    applyStimulus(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0); cycle();
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(0, 5'd8, 5'd0, 0, 0, 5'd8, 0, 1, 5'd0, 0); cycle();
    end
    checks++;
    if (obsStallCnt !== 16'hFFFF || obsOut !== 4'b0010) begin
      errors++; $display("[TB] FAIL saturation got %h out %b need ffff out 0010", obsStallCnt, obsOut);
    end
    idle(); cycle();
    checks++;
    if (obsStallCnt !== 16'hFFFF || obsFlushCnt !== cur.flushCnt) begin
      errors++; $display("[TB] FAIL saturation-hold got %h/%h need ffff/%h", obsStallCnt, obsFlushCnt, cur.flushCnt);
    end
  endtask

  initial begin
    reset = 1'b1; registerRsID = '0; registerRtID = '0; branchID = 1'b0; branchTaken = 1'b0;
    registerRdEX = '0; regWriteEX = 1'b0; memReadEX = 1'b0; registerRdMEM = '0; memReadMEM = 1'b0;
    @(negedge clock);
    test_reset();
    test_load_use();
    test_load_branch();
    test_reg_zero();
    test_alu_branch_taken();
    test_mem_branch();
    test_reset_in_hold();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
